// File: rtl/ascon_pack.sv
// Shared ASCON types and constants for the inverse permutation engine.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LIN,
    ST_SUB,
    ST_DONE
  } type_fsm;

  localparam logic [7:0] ROUND_CONSTANT [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  // Column value packs x0 as MSB, matching the forward S-box layer.
  localparam logic [4:0] INV_SBOX [32] = '{
    5'd20, 5'd26, 5'd7,  5'd13, 5'd0,  5'd9,  5'd14, 5'd18,
    5'd10, 5'd6,  5'd29, 5'd1,  5'd25, 5'd21, 5'd19, 5'd30,
    5'd24, 5'd22, 5'd11, 5'd17, 5'd3,  5'd5,  5'd28, 5'd31,
    5'd23, 5'd27, 5'd4,  5'd8,  5'd15, 5'd12, 5'd16, 5'd2
  };

  localparam logic [5:0] LIN_LAST   = 6'd62;
  localparam logic [3:0] MAX_ROUNDS = 4'd12;
  localparam logic [3:0] FIRST_RND  = 4'd11;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/inv_permutation_fsm_inv_substitution_layer.sv
// Inverse ASCON S-box applied to all 64 bit columns of the state.
module inv_substitution_layer
  import ascon_pack::*;
(
  input  type_state i_state,
  output type_state o_state
);

  for (genvar j = 0; j < 64; j++) begin : g_col
    logic [4:0] w_in;
    logic [4:0] w_out;
    assign w_in  = {i_state[0][j], i_state[1][j], i_state[2][j], i_state[3][j], i_state[4][j]};
    assign w_out = INV_SBOX[w_in];
    assign o_state[0][j] = w_out[4];
    assign o_state[1][j] = w_out[3];
    assign o_state[2][j] = w_out[2];
    assign o_state[3][j] = w_out[1];
    assign o_state[4][j] = w_out[0];
  end

endmodule

// File: rtl/inv_permutation_fsm.sv
// Iterative inverse ASCON permutation; linear inverse is L applied 63 times (L^64 = I).
module inv_permutation_fsm
  import ascon_pack::*;
(
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      start_i,
  input  logic [3:0] nrounds_i,
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      done_o
);

  type_fsm   r_fsm,   w_fsm_nxt;
  type_state r_state, w_state_nxt;
  logic [3:0] r_rnd,  w_rnd_nxt;
  logic [3:0] r_last, w_last_nxt;
  logic [5:0] r_lin,  w_lin_nxt;

  type_state  w_lin_out;
  type_state  w_sbox_out;
  type_state  w_sub_out;
  logic [3:0] w_n_eff;

  function automatic type_state lin_layer(input type_state s);
    type_state r;
    r[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
    r[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
    r[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
    r[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
    r[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);
    return r;
  endfunction

  assign w_lin_out = lin_layer(r_state);

  inv_substitution_layer u_inv_sub (
    .i_state (r_state),
    .o_state (w_sbox_out)
  );

  // Constant is removed after the inverse S-box since it was added before it going forward.
  always_comb begin
    w_sub_out = w_sbox_out;
    w_sub_out[2][7:0] = w_sbox_out[2][7:0] ^ ROUND_CONSTANT[r_rnd];
  end

  assign w_n_eff = (nrounds_i > MAX_ROUNDS) ? MAX_ROUNDS : nrounds_i;

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    w_last_nxt  = r_last;
    w_lin_nxt   = r_lin;
    case (r_fsm)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = state_i;
          w_rnd_nxt   = FIRST_RND;
          w_last_nxt  = MAX_ROUNDS - w_n_eff;
          w_lin_nxt   = 6'd0;
          w_fsm_nxt   = (w_n_eff == 4'd0) ? ST_DONE : ST_LIN;
        end
      end
      ST_LIN: begin
        w_state_nxt = w_lin_out;
        if (r_lin == LIN_LAST) begin
          w_lin_nxt = 6'd0;
          w_fsm_nxt = ST_SUB;
        end else begin
          w_lin_nxt = r_lin + 6'd1;
        end
      end
      ST_SUB: begin
        w_state_nxt = w_sub_out;
        if (r_rnd == r_last) begin
          w_fsm_nxt = ST_DONE;
        end else begin
          w_rnd_nxt = r_rnd - 4'd1;
          w_fsm_nxt = ST_LIN;
        end
      end
      ST_DONE: w_fsm_nxt = ST_IDLE;
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_rnd   <= '0;
      r_last  <= '0;
      r_lin   <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
      r_last  <= w_last_nxt;
      r_lin   <= w_lin_nxt;
    end
  end

  assign state_o = r_state;
  assign busy_o  = (r_fsm == ST_LIN) || (r_fsm == ST_SUB);
  assign done_o  = (r_fsm == ST_DONE);

endmodule

// File: tb/tb_inv_permutation_fsm.sv
// Directed bench: forward ASCON model builds Pk(S), the DUT must return S.
module tb_inv_permutation_fsm;
  import ascon_pack::*;

  logic       clock_i;
  logic       resetb_i;
  logic       start_i;
  logic [3:0] nrounds_i;
  type_state  state_i;
  type_state  state_o;
  logic       busy_o;
  logic       done_o;

  int tests = 0;
  int fails = 0;

  inv_permutation_fsm dut (
    .clock_i   (clock_i),
    .resetb_i  (resetb_i),
    .start_i   (start_i),
    .nrounds_i (nrounds_i),
    .state_i   (state_i),
    .state_o   (state_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference forward round: constant add, bitsliced S-box, linear diffusion.
  function automatic type_state fwd_round(input type_state s, input int r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [3:0]  hi, lo;
    type_state   o;
    hi = 4'(15 - r);
    lo = 4'(r);
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 ^= {56'd0, hi, lo};
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return o;
  endfunction

  function automatic type_state fwd(input type_state s, input int k);
    type_state t;
    t = s;
    for (int r = 12 - k; r < 12; r++) t = fwd_round(t, r);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Start a run, optionally pulse start_i after edge glitch_at, then check latency/busy/result.
  task automatic run(input logic [3:0] n, input type_state sin, input type_state sexp,
                     input int exp_k, input int glitch_at, input string tag);
    int k;
    int bc;
    bit seen;
    @(negedge clock_i);
    start_i = 1'b1; nrounds_i = n; state_i = sin;
    @(posedge clock_i); #1;
    start_i = 1'b0; state_i = ~sin;
    k = 0; bc = 0; seen = 1'b0;
    while (k < 1000) begin
      if (k == glitch_at) begin
        start_i = 1'b1; nrounds_i = 4'd1; state_i = ~sexp;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (busy_o) bc++;
      @(posedge clock_i); #1;
      k++;
    end
    chk({tag, "_done_seen"}, 320'(seen), 320'(1));
    chk({tag, "_latency"}, 320'(k), 320'(exp_k));
    chk({tag, "_busy_cycles"}, 320'(bc), 320'(exp_k));
    chk({tag, "_result"}, state_o, sexp);
    @(posedge clock_i); #1;
    start_i = 1'b0;
    chk({tag, "_done_pulse"}, 320'(done_o), 320'(0));
    chk({tag, "_idle_busy"}, 320'(busy_o), 320'(0));
    chk({tag, "_held"}, state_o, sexp);
  endtask

  type_state s0, p1, p6, p12, rs;
  int dones;

  initial begin
    s0 = '0;
    s0[0] = 64'h80400c0600000000;
    s0[1] = 64'h0123456789abcdef;
    s0[2] = 64'hfedcba9876543210;
    p1  = fwd(s0, 1);
    p6  = fwd(s0, 6);
    p12 = fwd(s0, 12);

    resetb_i = 1'b0; start_i = 1'b0; nrounds_i = 4'd0; state_i = '0;
    repeat (3) @(posedge clock_i);
    #1;
    chk("rst_state", state_o, '0);
    chk("rst_busy", 320'(busy_o), 320'(0));
    chk("rst_done", 320'(done_o), 320'(0));
    @(negedge clock_i);
    resetb_i = 1'b1;

    run(4'd1, p1, s0, 64, -1, "n1");
    run(4'd12, p12, s0, 768, -1, "n12");
    run(4'd0, s0, s0, 0, -1, "n0");
    run(4'd15, p12, s0, 768, -1, "n15_clamp");
    run(4'd6, p6, s0, 384, 100, "n6_glitch");
    run(4'd1, p1, s0, 64, 64, "n1_start_in_done");

    // Abort an n=12 run by reset at cycle 300.
    @(negedge clock_i);
    start_i = 1'b1; nrounds_i = 4'd12; state_i = p12;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    repeat (300) @(posedge clock_i);
    #1;
    resetb_i = 1'b0;
    #1;
    chk("abort_state", state_o, '0);
    chk("abort_busy", 320'(busy_o), 320'(0));
    chk("abort_done", 320'(done_o), 320'(0));
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_i);
      if (done_o) dones++;
    end
    resetb_i = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock_i);
      if (done_o) dones++;
    end
    chk("abort_no_done", 320'(dones), 320'(0));
    run(4'd1, p1, s0, 64, -1, "post_abort_n1");

    for (int t = 0; t < 20; t++) begin
      for (int w = 0; w < 5; w++) rs[w] = {$urandom, $urandom};
      run(4'd12, fwd(rs, 12), rs, 768, -1, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
